// File: rtl/counter_pkg.sv
// Shared types and constants for the counter sequencer.
// State encoding plus mode/direction literals.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;
  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;

endpackage

// File: rtl/counter_sequencer_tick_prescaler.sv
// Rate divider: one tick every prescale+1 enabled cycles.
// clear wins over enable; a disabled divider holds its phase.
module tick_prescaler #(
  parameter int PRE_BITS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                enable,
  input  logic [PRE_BITS-1:0] prescale,
  output logic                tick
);

  logic [PRE_BITS-1:0] cnt;

  assign tick = enable && (cnt == prescale);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Programmable timer: start/stop/pause, one-shot or reload,
// up or down, with a prescaled count rate and tc pulse.
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int PRE_BITS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic                pause,
  input  logic                mode,
  input  logic                dir,
  input  logic [BITS-1:0]     load_val,
  input  logic [PRE_BITS-1:0] prescale,
  output logic [BITS-1:0]     count,
  output logic                busy,
  output logic                done,
  output logic                tc_pulse
);

  state_t              state, state_n;
  logic [BITS-1:0]     count_n;
  logic                tc_n;
  logic                mode_q, dir_q;
  logic [BITS-1:0]     load_q;
  logic [PRE_BITS-1:0] pre_q;
  logic [BITS-1:0]     sv, tv;
  logic                active, run_en, tick;

  assign sv     = (dir_q == DIR_DOWN) ? load_q : '0;
  assign tv     = (dir_q == DIR_DOWN) ? '0 : load_q;
  assign active = (state == RUN) || (state == PAUSE);
  // Leaving PAUSE counts on the same edge, so a pause of
  // N cycles delays the run by exactly N cycles.
  assign run_en = active && !pause && !start && !stop;

  tick_prescaler #(
    .PRE_BITS(PRE_BITS)
  ) u_pre (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (start || stop),
    .enable  (run_en),
    .prescale(pre_q),
    .tick    (tick)
  );

  always_comb begin
    state_n = state;
    count_n = count;
    tc_n    = 1'b0;
    unique case (1'b1)
      stop: begin
        state_n = IDLE;
      end
      start && !stop: begin
        state_n = RUN;
        count_n = (dir == DIR_DOWN) ? load_val : '0;
      end
      !start && !stop: begin
        if (active) begin
          state_n = pause ? PAUSE : RUN;
          if (tick) begin
            if (count == tv) begin
              tc_n = 1'b1;
              if (mode_q == MODE_ONESHOT) begin
                state_n = DONE;
              end else begin
                count_n = sv;
              end
            end else if (dir_q == DIR_DOWN) begin
              count_n = count - 1'b1;
            end else begin
              count_n = count + 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tc_pulse <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      busy     <= (state_n == RUN) || (state_n == PAUSE);
      done     <= (state_n == DONE);
      tc_pulse <= tc_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= 1'b0;
      dir_q  <= 1'b0;
      load_q <= '0;
      pre_q  <= '0;
    end else if (start && !stop) begin
      mode_q <= mode;
      dir_q  <= dir;
      load_q <= load_val;
      pre_q  <= prescale;
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer (BITS=4, PRE_BITS=4).
// Immediate assertions against hand-computed expectations.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       mode = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] prescale = '0;
  logic [3:0] count;
  logic       busy, done, tc_pulse;

  int total = 0;
  int bad = 0;

  counter_sequencer #(
    .BITS    (4),
    .PRE_BITS(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .stop    (stop),
    .pause   (pause),
    .mode    (mode),
    .dir     (dir),
    .load_val(load_val),
    .prescale(prescale),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .tc_pulse(tc_pulse)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] c,
                         input logic b, input logic d,
                         input logic t);
    chk({tag, ".count"}, {4'd0, count}, {4'd0, c});
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
    chk({tag, ".done"}, {7'd0, done}, {7'd0, d});
    chk({tag, ".tc"}, {7'd0, tc_pulse}, {7'd0, t});
  endtask

  initial begin
    // asynchronous reset
    #1 reset_n = 1'b0;
    #1 chk_all("rst", 4'd0, 1'b0, 1'b0, 1'b0);
    #10 reset_n = 1'b1;

    // up, one-shot, load 5, prescale 0
    mode = 1'b0; dir = 1'b0; load_val = 4'd5; prescale = 4'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    load_val = 4'd2;
    chk_all("up_e0", 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk_all("up_run", 4'(i), 1'b1, 1'b0, 1'b0);
    end
    step();
    chk_all("up_tc", 4'd5, 1'b0, 1'b1, 1'b1);
    step();
    chk_all("up_hold", 4'd5, 1'b0, 1'b1, 1'b0);

    // down, reload, load 3, prescale 1 (started from DONE)
    mode = 1'b1; dir = 1'b1; load_val = 4'd3; prescale = 4'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk_all("dn_e0", 4'd3, 1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 16; e++) begin
      step();
      chk_all("dn_run", 4'(3 - (e % 8) / 2), 1'b1, 1'b0,
              (e % 8) == 0);
    end

    // stop from RUN holds count
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_all("stop", 4'd3, 1'b0, 1'b0, 1'b0);

    // up, one-shot, load 9, pause 4 cycles at count 4
    mode = 1'b0; dir = 1'b0; load_val = 4'd9; prescale = 4'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk_all("pz_e0", 4'd0, 1'b1, 1'b0, 1'b0);
    repeat (4) step();
    chk_all("pz_pre", 4'd4, 1'b1, 1'b0, 1'b0);
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_all("pz_hold", 4'd4, 1'b1, 1'b0, 1'b0);
    end
    pause = 1'b0;
    for (int i = 5; i <= 9; i++) begin
      step();
      chk_all("pz_run", 4'(i), 1'b1, 1'b0, 1'b0);
    end
    step();
    chk_all("pz_tc", 4'd9, 1'b0, 1'b1, 1'b1);

    // stop+start together at count 6, then start alone
    mode = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    chk_all("ss_pre", 4'd6, 1'b1, 1'b0, 1'b0);
    start = 1'b1; stop = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    chk_all("ss_stop", 4'd6, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("ss_idle", 4'd6, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_all("ss_start", 4'd0, 1'b1, 1'b0, 1'b0);

    // load 0, one-shot, prescale 2
    mode = 1'b0; dir = 1'b0; load_val = 4'd0; prescale = 4'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    chk_all("z_e0", 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk_all("z_wait", 4'd0, 1'b1, 1'b0, 1'b0);
    end
    step();
    chk_all("z_tc", 4'd0, 1'b0, 1'b1, 1'b1);

    // async reset mid-clock at count 7
    load_val = 4'd9; prescale = 4'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    chk_all("ar_pre", 4'd7, 1'b1, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk_all("ar_now", 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    #3 reset_n = 1'b1;
    step();
    step();
    chk_all("ar_idle", 4'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk_all("ar_run", 4'd1, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Programmable timer/counter controller. Owns a BITS-wide counter register and sequences it: start, stop, pause, one-shot vs auto-reload, up vs down, with a prescaler that sets the count rate.
- Sits between a control source (CPU register block or a top-level FSM) and the free-running counter datapath.
- Replaces ad-hoc free-running counters wherever a bounded, restartable count with a terminal-count event is needed.

Parameters:
- BITS, 8, width of the counter, load_val and count.
- PRE_BITS, 4, width of the prescale divider and its compare value.

Ports:
- clk  input  1  clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  level, sampled each clk; starts or restarts a count run.
- stop  input  1  level; aborts the run and returns to IDLE.
- pause  input  1  level; freezes the count while high in RUN.
- mode  input  1  0 = one-shot, 1 = auto-reload; captured at start.
- dir  input  1  0 = up (0 to load_val), 1 = down (load_val to 0); captured at start.
- load_val  input  BITS  terminal value (up) or start value (down); captured at start.
- prescale  input  PRE_BITS  one count step per prescale+1 clk cycles; captured at start.
- count  output  BITS  current count, registered.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  level, high in DONE.
- tc_pulse  output  1  one-cycle pulse per terminal count.

Behaviour:
- Reset (asynchronous, any time, including mid-run):
  - state = IDLE.
  - count, busy, done and tc_pulse = 0.
  - prescaler = 0 and shadow registers = 0.
- All outputs are registered; no combinational input-to-output paths.
- States: IDLE, RUN, PAUSE, DONE. Input priority each cycle: stop > start > pause.
- Start value: SV = dir ? load_val : 0. Terminal value: TV = dir ? 0 : load_val. Both are computed from captured values.
- Start (start=1, stop=0, any state):
  - Capture mode, dir, load_val and prescale.
  - count <= SV, prescaler <= 0, state <= RUN.
  - A start while in RUN or PAUSE restarts the run.
  - Visible at the edge that samples start (latency 1).
- Tick: asserted in RUN when prescaler == captured prescale. On a tick the prescaler goes to 0; otherwise it increments. prescale = 0 gives a tick every cycle.
- RUN, tick with count != TV: count <= count+1 (up) or count-1 (down).
- RUN, tick with count == TV:
  - tc_pulse <= 1 for one cycle.
  - One-shot: state <= DONE, count holds TV.
  - Auto-reload: count <= SV, stay in RUN.
- RUN with pause=1 and no start/stop: state <= PAUSE. The tick is suppressed that cycle, and the prescaler and count freeze.
- PAUSE with pause=0: state <= RUN, resuming from the frozen prescaler value.
- DONE: done=1, count holds TV. start begins a new run; stop goes to IDLE.
- stop (any state): state <= IDLE, count holds its last value, prescaler <= 0, done <= 0. tc_pulse is never asserted on the stop cycle.
- load_val = 0: SV == TV, so the first tick produces tc_pulse. An auto-reload run with load_val = 0 pulses every prescale+1 cycles.
- Arithmetic is modulo 2^BITS. No wrap ever occurs in normal operation because the count stops or reloads at TV.
- Input changes other than start/stop/pause have no effect mid-run; only the captured shadow values are used.

Decomposition:
- Shared package counter_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - constants MODE_ONESHOT = 0, MODE_RELOAD = 1, DIR_UP = 0, DIR_DOWN = 1.
- One sub-module, tick_prescaler:
  - inputs: clk, reset_n, clear, enable, prescale;
  - output: tick;
  - contains the PRE_BITS divider.
- The FSM, shadow registers and the count register live in counter_sequencer.

Test Plan:
- BITS=4, prescale=0, up, one-shot, load_val=5, start pulsed at edge 0 -> count 0,1,2,3,4,5 at edges 0–5; at edge 6 tc_pulse=1 for one cycle, done=1, busy=0, count=5.
- Down, auto-reload, load_val=3, prescale=1 -> count 3,3,2,2,1,1,0,0,3…; tc_pulse high exactly once every 8 cycles; done never set.
- Up, load_val=9, prescale=0, pause high for 4 cycles when count=4 -> count holds 4 and busy=1 throughout; resumes at 5; tc_pulse 4 cycles later than the unpaused run.
- stop and start asserted together mid-run at count=6 -> IDLE, count=6, busy=0, no tc_pulse; then start alone -> count=0, RUN.
- load_val=0, one-shot, prescale=2 -> tc_pulse and done 3 cycles after the start edge, count stays 0.
- reset_n dropped asynchronously mid-clock while in RUN at count=7 -> count, busy, done and tc_pulse = 0 immediately, without waiting for a clk edge; after release the block stays IDLE until start.
